ka_gf2_mul_seq: RTL and testbench

Parametrised, iterative, one-level Karatsuba carry-less (GF(2)[x]) multiplier. It is the sequential successor to the combinational 30-bit Karatsuba multipliers.
- One shared digit-serial sub-multiplier computes the three half-width products in sequence.
- Optional mode reduces the product modulo a runtime-supplied degree-N polynomial.
- Sits between operand producers and consumers on valid/ready streams.

---
 rtl/ka_gf2_mul_seq.sv | 211 +++++++++++++++++++++
 tb/tb_ka_gf2_mul_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ka_gf2_mul_seq.sv
// Iterative one-level Karatsuba carry-less multiplier over GF(2)[x].
// One shared digit-serial sub-multiplier produces the three half products; an optional pass reduces modulo x^N + poly.
module ka_gf2_mul_seq #(
  parameter int unsigned N = 30,
  parameter int unsigned D = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           red_en,
  input  logic [N-1:0]   poly,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] out_p
);

  localparam int unsigned H    = N / 2;
  localparam int unsigned HW   = 2 * H - 1;
  localparam int unsigned PW   = 2 * N - 1;
  localparam int unsigned NDIG = H / D;
  localparam int unsigned CW   = $clog2(N + 1);
  localparam int unsigned IW   = $clog2(PW);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P0,
    S_P1,
    S_P2,
    S_COMB,
    S_RED,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           red_q, red_d;
  logic [N-1:0]   poly_q, poly_d;
  logic [HW-1:0]  acc_q, acc_d;
  logic [HW-1:0]  t0_q, t0_d;
  logic [HW-1:0]  t1_q, t1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  p_q, p_d;
  logic [PW-1:0]  out_p_q, out_p_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;

  logic [H-1:0]   x_sel;
  logic [H-1:0]   y_sel;
  logic [HW-1:0]  partial;
  logic [HW-1:0]  acc_nxt;
  logic [IW-1:0]  red_idx;
  logic           last_dig;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      red_q       <= 1'b0;
      poly_q      <= '0;
      acc_q       <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      red_q       <= red_d;
      poly_q      <= poly_d;
      acc_q       <= acc_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state, sub-multiplier step and reduction step
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    red_d       = red_q;
    poly_d      = poly_q;
    acc_d       = acc_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    x_sel       = a_q[H-1:0];
    y_sel       = b_q[H-1:0];
    partial     = '0;
    red_idx     = IW'(PW - 1 - 32'(cnt_q));
    last_dig    = (cnt_q == CW'(NDIG - 1));

    case (state_q)
      S_P1: begin
        x_sel = a_q[N-1:H];
        y_sel = b_q[N-1:H];
      end
      S_P2: begin
        x_sel = a_q[N-1:H] ^ a_q[H-1:0];
        y_sel = b_q[N-1:H] ^ b_q[H-1:0];
      end
      default: begin
        x_sel = a_q[H-1:0];
        y_sel = b_q[H-1:0];
      end
    endcase

    // Only the D bits of the current digit contribute this cycle
    for (int unsigned j = 0; j < H; j++) begin
      if (y_sel[j] && (CW'(j / D) == cnt_q)) begin
        partial = partial ^ (HW'(x_sel) << j);
      end
    end
    acc_nxt = acc_q ^ partial;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          red_d   = red_en;
          poly_d  = poly;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_P0;
        end
      end
      S_P0: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_dig) begin
          t0_d    = acc_nxt;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_P1;
        end
      end
      S_P1: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_dig) begin
          t1_d    = acc_nxt;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_P2;
        end
      end
      S_P2: begin
        acc_d = acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (last_dig) begin
          cnt_d   = '0;
          state_d = S_COMB;
        end
      end
      S_COMB: begin
        // acc_q holds the middle-term product (Au^Al)*(Bu^Bl)
        p_d     = {t1_q, {N{1'b0}}} ^ (PW'(t0_q ^ t1_q ^ acc_q) << H) ^ PW'(t0_q);
        cnt_d   = '0;
        state_d = red_q ? S_RED : S_DONE;
      end
      S_RED: begin
        if (p_q[red_idx]) begin
          p_d = p_q ^ (PW'({1'b1, poly_q}) << (32'(red_idx) - N));
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 2)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered handshake outputs follow the upcoming state
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    out_p_d     = (state_d == S_DONE) ? p_d : '0;
  end

endmodule

// File: tb/tb_ka_gf2_mul_seq.sv
// Scoreboarded bench for ka_gf2_mul_seq: the driver pushes expected products into a queue,
// and an independent monitor pops and compares on every output handshake.
module tb_ka_gf2_mul_seq;

  localparam int unsigned N  = 30;
  localparam int unsigned D  = 5;
  localparam int unsigned PW = 2 * N - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          red_en;
  logic [N-1:0]  poly;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_p;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PW-1:0] exp_q[$];

  ka_gf2_mul_seq #(.N(N), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .red_en    (red_en),
    .poly      (poly),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Bit-serial reference multiply and schoolbook reduction
  function automatic logic [PW-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (y[i]) r = r ^ (PW'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [PW-1:0] gfmod(input logic [PW-1:0] p, input logic [N-1:0] pl);
    logic [PW-1:0] r;
    r = p;
    for (int i = PW - 1; i >= N; i--) begin
      if (r[i]) r = r ^ (PW'({1'b1, pl}) << (i - N));
    end
    return r;
  endfunction

  // Monitor: every output handshake must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got %h, expected no result", out_p);
      end else begin
        check("result", out_p, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at handshake posedge+1
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tr,
                      input logic [N-1:0] tp, input logic [PW-1:0] exp, input bit track);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready=%0b, expected 1", in_ready);
    end
    a = ta; b = tb; red_en = tr; poly = tp; in_valid = 1'b1;
    if (track) exp_q.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb; red_en = ~tr; poly = ~tp;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 100);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int seen;
    logic [N-1:0]  ra, rb, rp;
    logic          rr;
    logic [PW-1:0] rexp;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; red_en = 1'b0; poly = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", PW'(in_ready), PW'(1));
    check("rst_out_valid", PW'(out_valid), PW'(0));
    check("rst_out_p", out_p, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Plain multiply, latency and hand-computed products
    send(30'h1, 30'h1, 1'b0, 30'h0, 59'h1, 1'b1);
    wait_valid(cyc);
    check("lat_plain", PW'(cyc), PW'(10));
    send(30'h3, 30'h3, 1'b0, 30'h0, 59'h5, 1'b1);
    send(30'h3FFF_FFFF, 30'h1, 1'b0, 30'h0, 59'h3FFF_FFFF, 1'b1);
    send(30'h2000_0000, 30'h2000_0000, 1'b0, 30'h0, 59'h400_0000_0000_0000, 1'b1);
    send(30'h3FFF_FFFF, 30'h3FFF_FFFF, 1'b0, 30'h0, 59'h555_5555_5555_5555, 1'b1);
    send(30'h0, 30'h123_4567, 1'b0, 30'h0, 59'h0, 1'b1);

    // Reduction
    send(30'h2000_0000, 30'h2, 1'b1, 30'h3, 59'h3, 1'b1);
    wait_valid(cyc);
    check("lat_red", PW'(cyc), PW'(39));
    send(30'h2000_0000, 30'h2, 1'b1, 30'h0, 59'h0, 1'b1);
    send(30'h3FFF_FFFF, 30'h3, 1'b1, 30'h0, 59'h1, 1'b1);
    send(30'h3, 30'h3, 1'b1, 30'h3, 59'h5, 1'b1);

    // Backpressure with an ignored request during P1
    while (!in_ready) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    send(30'h155, 30'h3, 1'b0, 30'h0, 59'h3FF, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check("p1_in_ready", PW'(in_ready), PW'(0));
    a = 30'h7; b = 30'h7; red_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(cyc);
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", PW'(out_valid), PW'(1));
      check("bp_out_p", out_p, 59'h3FF);
      check("bp_in_ready", PW'(in_ready), PW'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", PW'(in_ready), PW'(1));
    check("release_out_valid", PW'(out_valid), PW'(0));
    send(30'h3, 30'h3, 1'b0, 30'h0, 59'h5, 1'b1);

    // Reset during P2 discards the in-flight operation
    send(30'h2AAA_AAAA, 30'h1555_5555, 1'b0, 30'h0, 59'h0, 1'b0);
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_in_ready", PW'(in_ready), PW'(1));
    check("mid_rst_out_valid", PW'(out_valid), PW'(0));
    check("mid_rst_out_p", out_p, '0);
    seen = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("no_stale", PW'(seen), PW'(0));
    send(30'h3, 30'h3, 1'b0, 30'h0, 59'h5, 1'b1);

    // Random pairs against the reference model
    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rp = N'($urandom);
      rr = 1'($urandom_range(0, 1));
      rexp = rr ? gfmod(clmul(ra, rb), rp) : clmul(ra, rb);
      send(ra, rb, rr, rp, rexp, 1'b1);
    end

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_results: %0d outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
